dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-ported data memory between the pipeline's MEM stage and a video scan-out reader. The reader issues word-read bursts. The CPU has priority, but a bounded-wait counter guarantees the reader forward progress; when the reader takes a slot it stalls the MEM stage for exactly that cycle. The block sits between the EX/MEM pipeline register outputs and the data memory, and also feeds the hazard logic's pipeline-hold input.

## Interface

**Parameters**
- `BURST_LEN`, default 16: words per video burst (1..255).
- `MAX_WAIT`, default 4: maximum consecutive cycles a pending video word may lose to the CPU (1..15).

**Ports** (clock and reset first)
- `Clk` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: synchronous, active-high.
- `cpu_req` in 1: MEM stage wants memory this cycle, i.e. `cpu_rd != 0` or `cpu_wr != 0`.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: store data.
- `cpu_wr` in 2: MemWrite code.
- `cpu_rd` in 2: MemRead code.
- `cpu_rdata` out 32: load data; combinational from `mem_rdata`.
- `cpu_stall` out 1: hold the IF..MEM stages this cycle.
- `vid_start` in 1: one-cycle pulse that requests a burst.
- `vid_base` in 32: burst start address, sampled on `vid_start`; bits [1:0] are forced to 0.
- `vid_busy` out 1: a burst is in progress.
- `vid_valid` out 1: `vid_rdata` holds a burst word.
- `vid_rdata` out 32: registered read word.
- `vid_done` out 1: high with the last `vid_valid` of a burst.
- `mem_addr` out 32, `mem_wdata` out 32, `mem_wr` out 2, `mem_rd` out 2: to the data memory.
- `mem_rdata` in 32: combinational read data from the data memory.

## Operation

**States**
- `IDLE`
  - Entered from reset or after the last burst grant.
  - On `vid_start`: load `ptr = {vid_base[31:2], 2'b00}`, `remaining = BURST_LEN`, `wait_cnt = 0`, go to `BURST`.
- `BURST`
  - Each cycle, video is granted if `!cpu_req || wait_cnt == MAX_WAIT`. Otherwise the CPU is granted.
  - **Video grant:**
    - `mem_addr = ptr`, `mem_rd = MEM_WORD`, `mem_wr = MEM_NONE`.
    - `cpu_stall = cpu_req`.
    - Next edge: `vid_rdata <= mem_rdata`, `vid_valid <= 1`, `ptr <= ptr + 4` (wraps modulo 2^32), `remaining <= remaining - 1`, `wait_cnt <= 0`.
    - If `remaining == 1`: `vid_done <= 1` and go to `IDLE`.
  - **CPU grant while video pending:**
    - The `mem_*` outputs follow the `cpu_*` inputs.
    - `wait_cnt <= wait_cnt + 1`.
- **CPU path:** in `IDLE`, and in any `BURST` cycle without a video grant, the `mem_*` outputs pass the `cpu_*` inputs through and `cpu_stall = 0`.
- **`vid_start` outside `IDLE`:** ignored; no restart and no queueing.
- **`vid_start` in the same cycle as the last grant:** ignored, because the state is still `BURST`.
- **`cpu_req = 0` while idle:** `mem_wr = mem_rd = MEM_NONE`, `mem_addr = cpu_addr`.
- **`cpu_rdata`:** always equals `mem_rdata`. The pipeline ignores it while `cpu_stall` is high.
- **Reset mid-burst:** the burst is aborted. No further `vid_valid` is produced and the state returns to `IDLE`.

## Timing

**Reset values**
- State is `IDLE`.
- `vid_busy`, `vid_valid`, `vid_done`: 0.
- `vid_rdata`: 0.
- `ptr`, `remaining`, `wait_cnt`: 0.
- `cpu_stall`: 0.

**Latency and throughput**
- Latency from a video grant cycle to `vid_valid` is 1 cycle.
- `vid_valid` and `vid_done` are single-cycle pulses per word.
- `vid_busy` rises the cycle after `vid_start`. It falls the cycle after the last grant, which is the same cycle `vid_done` is high.
- Minimum burst duration with an idle CPU: BURST_LEN cycles of grants, first `vid_valid` 2 cycles after `vid_start`.
- Under saturated CPU traffic the video gets 1 slot per `MAX_WAIT + 1` cycles, and `cpu_stall` is high exactly in those slots.

**Combinational paths**
- `cpu_stall` and the `mem_*` outputs are combinational from state and `cpu_req`. Neither depends on `mem_rdata`.
- `cpu_stall` must not depend on `cpu_rdata`, so no loop exists through the hazard unit.

## Structure

- **Shared package** `mem_pkg`:
  - `MEM_NONE = 2'b00`.
  - `MEM_WORD = 2'b01`.
  - State enum: `ARB_IDLE`, `ARB_BURST`.
- **Width rules:**
  - `remaining` is `$clog2(BURST_LEN+1)` bits.
  - `wait_cnt` is 4 bits.
- **Sub-modules:** none required. Grant decode, counters and the output mux live in `dmem_arbiter`.

## Test plan

1. **Idle CPU burst.** `BURST_LEN=4`, `cpu_req=0`, `vid_start` with `vid_base=0x103`, memory preloaded `word[0x100..0x10C] = 0xA0..0xA3`.
   - `vid_valid` on 4 consecutive cycles starting 2 cycles after start.
   - `vid_rdata = 0xA0, 0xA1, 0xA2, 0xA3`.
   - `mem_addr = 0x100, 0x104, 0x108, 0x10C`.
   - `vid_done` with `0xA3`; `cpu_stall` never high.
2. **Saturated CPU.** `cpu_req=1` every cycle, `MAX_WAIT=4`, `BURST_LEN=3`.
   - `cpu_stall` high on cycles 5, 10 and 15 after `vid_busy` rises.
   - `mem_addr` equals the burst pointer only on those cycles.
   - `vid_done` 1 cycle after the third stall.
3. **CPU store pass-through.** No burst; `cpu_wr=MEM_WORD`, `cpu_addr=0x40`, `cpu_wdata=0xDEADBEEF`.
   - `mem_*` mirror the inputs in the same cycle, `cpu_stall=0`.
   - A subsequent load from 0x40 returns `0xDEADBEEF` on `cpu_rdata`.
4. **Restart ignored.** A second `vid_start` with `vid_base=0x200` mid-burst.
   - The burst continues from the original pointer with the original count.
   - No 0x200 access occurs; exactly `BURST_LEN` valids.
5. **Address wrap.** `vid_base=0xFFFFFFFC`, `BURST_LEN=2`.
   - `mem_addr = 0xFFFFFFFC`, then `0x00000000`.
6. **Reset mid-burst.** `Reset` held 1 cycle after the 2nd valid of a 4-word burst.
   - Next cycle: `vid_busy=0`, `vid_valid=0`.
   - No further valids; `cpu_stall=0`.
   - A new `vid_start` then completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared data-memory access codes and arbiter state encoding.
// Used by dmem_arbiter and anything else that drives the data memory.
package mem_pkg;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_WORD = 2'b01;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WAIT_W = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_BURST
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the MEM stage
// and the video scan-out burst reader. The CPU has priority, but a pending
// video word never loses more than MAX_WAIT consecutive cycles.
// Ports:
//   Clk, Reset                          clock, synchronous active-high reset
//   cpu_req/addr/wdata/wr/rd, cpu_rdata MEM-stage request and load data
//   cpu_stall                           holds IF..MEM during a video slot
//   vid_start, vid_base                 burst request pulse and start address
//   vid_busy/valid/rdata/done           burst status and returned words
//   mem_addr/wdata/wr/rd, mem_rdata     data memory port
module dmem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_wr,
  input  logic [1:0]  cpu_rd,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        vid_start,
  input  logic [31:0] vid_base,
  output logic        vid_busy,
  output logic        vid_valid,
  output logic [31:0] vid_rdata,
  output logic        vid_done,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_wr,
  output logic [1:0]  mem_rd,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned REM_W = $clog2(BURST_LEN + 1);

  arb_state_t        state;
  logic [31:0]       ptr;
  logic [REM_W-1:0]  remaining;
  logic [WAIT_W-1:0] wait_cnt;
  logic              vid_grant;

  // Video wins when the CPU is quiet or the pending word has waited long enough.
  assign vid_grant = (state == ARB_BURST) &&
                     (!cpu_req || (wait_cnt == WAIT_W'(MAX_WAIT)));

  assign cpu_stall = vid_grant && cpu_req;
  assign cpu_rdata = mem_rdata;
  assign vid_busy  = (state == ARB_BURST);

  // Memory port mux: CPU pass-through unless the video owns this slot.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_wr    = cpu_wr;
    mem_rd    = cpu_rd;
    if (!cpu_req) begin
      mem_wr = MEM_NONE;
      mem_rd = MEM_NONE;
    end
    if (vid_grant) begin
      mem_addr = ptr;
      mem_wr   = MEM_NONE;
      mem_rd   = MEM_WORD;
    end
  end

  // Burst FSM, pointer/count/wait counters and registered video outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      remaining <= '0;
      wait_cnt  <= '0;
      vid_valid <= 1'b0;
      vid_done  <= 1'b0;
      vid_rdata <= '0;
    end else begin
      vid_valid <= 1'b0;
      vid_done  <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (vid_start) begin
            ptr       <= vid_base & ~32'h0000_0003;
            remaining <= REM_W'(BURST_LEN);
            wait_cnt  <= '0;
            state     <= ARB_BURST;
          end
        end
        ARB_BURST: begin
          if (vid_grant) begin
            vid_rdata <= mem_rdata;
            vid_valid <= 1'b1;
            ptr       <= ptr + 32'd4;
            remaining <= remaining - REM_W'(1);
            wait_cnt  <= '0;
            if (remaining == REM_W'(1)) begin
              vid_done <= 1'b1;
              state    <= ARB_IDLE;
            end
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a simple behavioural data memory.
module tb_dmem_arbiter;
  import mem_pkg::*;

  localparam int unsigned BL = 4;
  localparam int unsigned MW = 4;

  logic        Clk, Reset;
  logic        cpu_req;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [1:0]  cpu_wr, cpu_rd;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        vid_start;
  logic [31:0] vid_base;
  logic        vid_busy, vid_valid, vid_done;
  logic [31:0] vid_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_wr, mem_rd;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:1023];

  dmem_arbiter #(.BURST_LEN(BL), .MAX_WAIT(MW)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .vid_start(vid_start), .vid_base(vid_base), .vid_busy(vid_busy),
    .vid_valid(vid_valid), .vid_rdata(vid_rdata), .vid_done(vid_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Power-on content of word index i (4 KB aliasing).
  function automatic logic [31:0] pat(input logic [31:0] a);
    logic [9:0] idx;
    idx = a[11:2];
    if (idx >= 10'd64 && idx < 10'd68) return 32'hA0 + 32'(idx - 10'd64);
    return 32'hC0DE_0000 | 32'(idx);
  endfunction

  // Data memory: reloaded while Reset is high, word writes otherwise.
  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(32'(i) << 2);
    end else if (mem_wr != MEM_NONE) begin
      mem[mem_addr[11:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[11:2]];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_addr = 32'h800; cpu_wdata = '0;
    cpu_wr = MEM_NONE; cpu_rd = MEM_NONE;
    vid_start = 1'b0; vid_base = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1'b1;
    cpu_req = 1'b1; cpu_rd = MEM_WORD; cpu_addr = 32'h124;
    tick(); tick();
    checks++; if (vid_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", vid_busy); end
    checks++; if (vid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", vid_valid); end
    checks++; if (vid_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", vid_done); end
    checks++; if (vid_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", vid_rdata); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
    checks++; if (mem_addr !== 32'h124) begin errors++; $display("FAIL reset_addr: got %h want 124", mem_addr); end
    Reset = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_idle_burst();
    idle_inputs();
    vid_base = 32'h103; vid_start = 1'b1;
    #1;
    checks++; if (mem_rd !== MEM_NONE || mem_wr !== MEM_NONE || mem_addr !== 32'h800) begin
      errors++; $display("FAIL idle_noreq: got addr=%h rd=%b wr=%b want 800/00/00", mem_addr, mem_rd, mem_wr); end
    tick();
    vid_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (k < 4) begin
        checks++; if (mem_addr !== 32'h100 + 32'(4 * k) || mem_rd !== MEM_WORD) begin
          errors++; $display("FAIL idle_addr[%0d]: got %h/%b want %h/01", k, mem_addr, mem_rd, 32'h100 + 32'(4 * k)); end
      end
      checks++; if (vid_valid !== (k >= 1 && k <= 4)) begin
        errors++; $display("FAIL idle_valid[%0d]: got %b", k, vid_valid); end
      if (k >= 1 && k <= 4) begin
        checks++; if (vid_rdata !== 32'hA0 + 32'(k - 1)) begin
          errors++; $display("FAIL idle_rdata[%0d]: got %h want %h", k, vid_rdata, 32'hA0 + 32'(k - 1)); end
      end
      checks++; if (vid_done !== (k == 4)) begin errors++; $display("FAIL idle_done[%0d]: got %b", k, vid_done); end
      checks++; if (vid_busy !== (k < 4)) begin errors++; $display("FAIL idle_busy[%0d]: got %b", k, vid_busy); end
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL idle_stall[%0d]: got %b want 0", k, cpu_stall); end
      tick();
    end
  endtask

  task automatic test_saturated();
    int last;
    idle_inputs();
    cpu_req = 1'b1; cpu_rd = MEM_WORD; cpu_addr = 32'h880;
    vid_base = 32'h140; vid_start = 1'b1;
    tick();
    vid_start = 1'b0;
    last = int'(BL) * int'(MW + 1);
    for (int i = 0; i <= last + 1; i++) begin
      logic slot;
      logic [31:0] ea;
      #1;
      slot = (i % int'(MW + 1) == int'(MW)) && (i < last);
      ea = slot ? 32'h140 + 32'(4 * (i / int'(MW + 1))) : 32'h880;
      checks++; if (cpu_stall !== slot) begin errors++; $display("FAIL sat_stall[%0d]: got %b want %b", i, cpu_stall, slot); end
      checks++; if (mem_addr !== ea) begin errors++; $display("FAIL sat_addr[%0d]: got %h want %h", i, mem_addr, ea); end
      checks++; if (vid_done !== (i == last)) begin errors++; $display("FAIL sat_done[%0d]: got %b", i, vid_done); end
      checks++; if (vid_busy !== (i < last)) begin errors++; $display("FAIL sat_busy[%0d]: got %b", i, vid_busy); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_restart_ignored();
    int nvalid;
    idle_inputs();
    nvalid = 0;
    vid_base = 32'h300; vid_start = 1'b1;
    tick();
    vid_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      // second start mid-burst and again on the final grant cycle
      vid_start = (k == 1 || k == 3);
      vid_base = 32'h200;
      #1;
      if (k < 4) begin
        checks++; if (mem_addr !== 32'h300 + 32'(4 * k)) begin
          errors++; $display("FAIL restart_addr[%0d]: got %h want %h", k, mem_addr, 32'h300 + 32'(4 * k)); end
      end
      checks++; if (mem_rd == MEM_WORD && mem_addr == 32'h200) begin
        errors++; $display("FAIL restart_0x200[%0d]: got access to %h", k, mem_addr); end
      if (vid_valid === 1'b1) nvalid++;
      tick();
    end
    vid_start = 1'b0;
    checks++; if (nvalid != int'(BL)) begin errors++; $display("FAIL restart_count: got %0d want %0d", nvalid, BL); end
    checks++; if (vid_busy !== 1'b0) begin errors++; $display("FAIL restart_busy: got %b want 0", vid_busy); end
  endtask

  task automatic test_wrap();
    logic [31:0] ea;
    idle_inputs();
    vid_base = 32'hFFFF_FFFE; vid_start = 1'b1;
    tick();
    vid_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (k < 4) begin
        ea = 32'hFFFF_FFFC + 32'(4 * k);
        checks++; if (mem_addr !== ea) begin errors++; $display("FAIL wrap_addr[%0d]: got %h want %h", k, mem_addr, ea); end
      end
      if (k >= 1) begin
        ea = 32'hFFFF_FFFC + 32'(4 * (k - 1));
        checks++; if (vid_valid !== 1'b1 || vid_rdata !== pat(ea)) begin
          errors++; $display("FAIL wrap_rdata[%0d]: got %b/%h want 1/%h", k, vid_valid, vid_rdata, pat(ea)); end
      end
      tick();
    end
  endtask

  // Random CPU traffic and starts against a counting model of the arbiter.
  task automatic test_random();
    logic        m_busy, m_valid, m_done;
    logic [31:0] m_addr, m_data;
    int          m_left, m_loss;
    logic        grant;
    logic [31:0] ea;
    idle_inputs();
    m_busy = 1'b0; m_valid = 1'b0; m_done = 1'b0; m_addr = '0; m_data = '0;
    m_left = 0; m_loss = 0;
    for (int c = 0; c < 400; c++) begin
      cpu_req = ($urandom_range(0, 9) < 7);
      cpu_rd = cpu_req ? MEM_WORD : MEM_NONE;
      cpu_addr = {20'h0, 2'b00, $urandom_range(0, 1023) > 0 ? 10'($urandom_range(0, 1023)) : 10'd0} << 2;
      vid_start = ($urandom_range(0, 7) == 0);
      vid_base = $urandom;
      #1;
      grant = m_busy && (!cpu_req || m_loss >= int'(MW));
      ea = grant ? m_addr : cpu_addr;
      checks++; if (cpu_stall !== (grant && cpu_req)) begin errors++; $display("FAIL rnd_stall[%0d]: got %b want %b", c, cpu_stall, grant && cpu_req); end
      checks++; if (mem_addr !== ea) begin errors++; $display("FAIL rnd_addr[%0d]: got %h want %h", c, mem_addr, ea); end
      checks++; if (vid_busy !== m_busy) begin errors++; $display("FAIL rnd_busy[%0d]: got %b want %b", c, vid_busy, m_busy); end
      checks++; if (vid_valid !== m_valid || vid_done !== m_done) begin
        errors++; $display("FAIL rnd_valid[%0d]: got %b/%b want %b/%b", c, vid_valid, vid_done, m_valid, m_done); end
      if (m_valid) begin
        checks++; if (vid_rdata !== m_data) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", c, vid_rdata, m_data); end
      end
      m_valid = grant; m_done = 1'b0;
      if (grant) begin
        m_data = pat(m_addr);
        m_addr = m_addr + 32'd4;
        m_left--; m_loss = 0;
        if (m_left == 0) begin m_done = 1'b1; m_busy = 1'b0; end
      end else if (m_busy) begin
        m_loss++;
      end else if (vid_start) begin
        m_busy = 1'b1; m_addr = {vid_base[31:2], 2'b00}; m_left = int'(BL); m_loss = 0;
      end
      tick();
    end
    idle_inputs();
    for (int c = 0; c < 40; c++) tick();
  endtask

  task automatic test_reset_mid_burst();
    int nvalid;
    idle_inputs();
    vid_base = 32'h500; vid_start = 1'b1;
    tick();
    vid_start = 1'b0;
    tick(); tick();
    #1;
    checks++; if (vid_valid !== 1'b1 || vid_rdata !== pat(32'h504)) begin
      errors++; $display("FAIL rst_second_valid: got %b/%h want 1/%h", vid_valid, vid_rdata, pat(32'h504)); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
    checks++; if (vid_busy !== 1'b0 || vid_valid !== 1'b0) begin
      errors++; $display("FAIL rst_abort: got busy=%b valid=%b want 0/0", vid_busy, vid_valid); end
    cpu_req = 1'b1; cpu_rd = MEM_WORD;
    nvalid = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall[%0d]: got %b want 0", k, cpu_stall); end
      if (vid_valid === 1'b1) nvalid++;
      tick();
    end
    checks++; if (nvalid != 0) begin errors++; $display("FAIL rst_no_valid: got %0d want 0", nvalid); end
    idle_inputs();
    vid_base = 32'h600; vid_start = 1'b1;
    tick();
    vid_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (k >= 1 && k <= 4) begin
        checks++; if (vid_valid !== 1'b1 || vid_rdata !== pat(32'h600 + 32'(4 * (k - 1))) || vid_done !== (k == 4)) begin
          errors++; $display("FAIL rst_restart[%0d]: got %b/%h/%b", k, vid_valid, vid_rdata, vid_done); end
      end
      tick();
    end
  endtask

  task automatic test_store_passthrough();
    idle_inputs();
    cpu_req = 1'b1; cpu_wr = MEM_WORD; cpu_addr = 32'h40; cpu_wdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (mem_addr !== 32'h40 || mem_wdata !== 32'hDEAD_BEEF || mem_wr !== MEM_WORD || mem_rd !== MEM_NONE) begin
      errors++; $display("FAIL store_mirror: got %h/%h/%b/%b", mem_addr, mem_wdata, mem_wr, mem_rd); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL store_stall: got %b want 0", cpu_stall); end
    tick();
    cpu_wr = MEM_NONE; cpu_rd = MEM_WORD; cpu_wdata = '0;
    #1;
    checks++; if (cpu_rdata !== 32'hDEAD_BEEF || mem_rd !== MEM_WORD) begin
      errors++; $display("FAIL store_load: got %h/%b want deadbeef/01", cpu_rdata, mem_rd); end
    tick();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_idle_burst();
    test_saturated();
    test_restart_ignored();
    test_wrap();
    test_random();
    test_reset_mid_burst();
    test_store_passthrough();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
